// File: rtl/led_ring_controller.sv
// Rotary-encoder front end for a WS2812B ring: cursor, display mode, intensity and refresh request.
// Build option: define LED_CTRL_WRAP_EN to make the cursor wrap at the ring ends instead of saturating.
module led_ring_controller #(
  parameter int N_LEDS = 12,
  parameter int INT_W  = 8,
  parameter int INT_L0 = 1,
  parameter int INT_L1 = 2,
  parameter int INT_L2 = 8,
  parameter int INT_L3 = 32,
  localparam int POS_W = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              rot_up,
  input  logic              rot_dn,
  input  logic              push,
  input  logic [1:0]        intensity_in,
  input  logic              refresh_ack,
  output logic              refresh_req,
  output logic [N_LEDS-1:0] led_mask,
  output logic [INT_W-1:0]  intensity_out,
  output logic [POS_W-1:0]  pos_out,
  output logic [1:0]        mode_out
);

  typedef enum logic [1:0] {
    DOT     = 2'd0,
    BAR     = 2'd1,
    DOT_INV = 2'd2,
    BAR_INV = 2'd3
  } mode_e;

  localparam logic [POS_W-1:0] MAX_POS = POS_W'(N_LEDS - 1);
  localparam logic [INT_W-1:0] LV0 = INT_W'(INT_L0);
  localparam logic [INT_W-1:0] LV1 = INT_W'(INT_L1);
  localparam logic [INT_W-1:0] LV2 = INT_W'(INT_L2);
  localparam logic [INT_W-1:0] LV3 = INT_W'(INT_L3);

  mode_e            mode_q, mode_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [INT_W-1:0] int_q, int_d;
  logic             req_q, req_d;
  logic             step_up, step_dn, change;
  logic [N_LEDS-1:0] dot_m, bar_m;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mode_q <= DOT;
      pos_q  <= '0;
      int_q  <= LV0;
      req_q  <= 1'b1;
    end else begin
      mode_q <= mode_d;
      pos_q  <= pos_d;
      int_q  <= int_d;
      req_q  <= req_d;
    end
  end

  // Simultaneous up and down cancel out.
  always_comb begin
    step_up = rot_up & ~rot_dn;
    step_dn = rot_dn & ~rot_up;
    pos_d   = pos_q;
    if (step_up) begin
`ifdef LED_CTRL_WRAP_EN
      pos_d = (pos_q == MAX_POS) ? '0 : pos_q + 1'b1;
`else
      if (pos_q != MAX_POS) pos_d = pos_q + 1'b1;
`endif
    end else if (step_dn) begin
`ifdef LED_CTRL_WRAP_EN
      pos_d = (pos_q == '0) ? MAX_POS : pos_q - 1'b1;
`else
      if (pos_q != '0) pos_d = pos_q - 1'b1;
`endif
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (push) begin
      unique case (mode_q)
        DOT:     mode_d = BAR;
        BAR:     mode_d = DOT_INV;
        DOT_INV: mode_d = BAR_INV;
        BAR_INV: mode_d = DOT;
      endcase
    end
  end

  always_comb begin
    int_d = LV0;
    unique case (intensity_in)
      2'b00: int_d = LV0;
      2'b01: int_d = LV1;
      2'b10: int_d = LV2;
      2'b11: int_d = LV3;
    endcase
  end

  // A change in the ack cycle keeps the request alive.
  always_comb begin
    change = (pos_d != pos_q) | (mode_d != mode_q) | (int_d != int_q);
    req_d  = req_q;
    if (change)
      req_d = 1'b1;
    else if (refresh_ack)
      req_d = 1'b0;
  end

  always_comb begin
    dot_m = '0;
    bar_m = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      dot_m[i] = (POS_W'(i) == pos_q);
      bar_m[i] = (POS_W'(i) <= pos_q);
    end
  end

  always_comb begin
    led_mask = dot_m;
    unique case (mode_q)
      DOT:     led_mask = dot_m;
      BAR:     led_mask = bar_m;
      DOT_INV: led_mask = ~dot_m;
      BAR_INV: led_mask = ~bar_m;
    endcase
  end

  assign refresh_req   = req_q;
  assign intensity_out = int_q;
  assign pos_out       = pos_q;
  assign mode_out      = mode_q;

endmodule

// File: tb/tb_led_ring_controller.sv
// Bench for led_ring_controller: directed scenarios plus random stimulus
// against an arithmetic reference model, compared every falling edge.
module tb_led_ring_controller;

  localparam int N  = 12;
  localparam int IW = 8;
  localparam int PW = $clog2(N);

  logic          clk = 1'b0;
  logic          res;
  logic          rot_up, rot_dn, push, refresh_ack;
  logic [1:0]    intensity_in;
  logic          refresh_req;
  logic [N-1:0]  led_mask;
  logic [IW-1:0] intensity_out;
  logic [PW-1:0] pos_out;
  logic [1:0]    mode_out;

  led_ring_controller #(.N_LEDS(N), .INT_W(IW)) dut (
    .clk(clk), .res(res), .rot_up(rot_up), .rot_dn(rot_dn), .push(push),
    .intensity_in(intensity_in), .refresh_ack(refresh_ack),
    .refresh_req(refresh_req), .led_mask(led_mask),
    .intensity_out(intensity_out), .pos_out(pos_out), .mode_out(mode_out)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  int m_pos, m_mode, m_int, m_req;
  int tbl [4] = '{1, 2, 8, 32};

  task automatic chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic longint exp_mask();
    longint m;
    longint all;
    all = (64'd1 << N) - 1;
    if (m_mode % 2 == 0) m = 64'd1 << m_pos;
    else m = (64'd1 << (m_pos + 1)) - 1;
    if (m_mode >= 2) m = ~m & all;
    return m;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_int = tbl[0] % (1 << IW); m_req = 1;
  endtask

  task automatic model_step();
    int np, nm, ni;
    bit chg;
    np = m_pos;
    if (rot_up && !rot_dn) np = np + 1;
    else if (rot_dn && !rot_up) np = np - 1;
`ifdef LED_CTRL_WRAP_EN
    np = (np + N) % N;
`else
    if (np < 0) np = 0;
    if (np > N - 1) np = N - 1;
`endif
    nm = push ? (m_mode + 1) % 4 : m_mode;
    ni = tbl[intensity_in] % (1 << IW);
    chg = (np != m_pos) || (nm != m_mode) || (ni != m_int);
    if (chg) m_req = 1;
    else if (refresh_ack) m_req = 0;
    m_pos = np; m_mode = nm; m_int = ni;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!res) model_step();
    #1;
  endtask

  task automatic drive(bit u, bit d, bit p, bit a);
    rot_up = u; rot_dn = d; push = p; refresh_ack = a;
  endtask

  always @(negedge clk) begin
    chk("pos", pos_out, m_pos);
    chk("mode", mode_out, m_mode);
    chk("intensity", intensity_out, m_int);
    chk("req", refresh_req, m_req);
    chk("mask", led_mask, exp_mask());
  end

  initial begin
    res = 1'b1;
    drive(0, 0, 0, 0);
    intensity_in = 2'b00;
    model_reset();
    repeat (2) tick();
    res = 1'b0;
    tick();
    chk("rst_mask", led_mask, 12'h001);
    chk("rst_int", intensity_out, 8'd1);
    chk("rst_mode", mode_out, 0);
    chk("rst_req", refresh_req, 1);
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    chk("ack_clears", refresh_req, 0);

    repeat (3) begin drive(1, 0, 0, 0); tick(); end
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    chk("bar_pos", pos_out, 3);
    chk("bar_mode", mode_out, 1);
    chk("bar_mask", led_mask, 12'h00F);
    repeat (2) begin drive(0, 0, 1, 0); tick(); end
    drive(0, 0, 0, 0);
    chk("barinv_mode", mode_out, 3);
    chk("barinv_mask", led_mask, 12'hFF0);

    drive(0, 0, 1, 0); tick();
    repeat (8) begin drive(1, 0, 0, 0); tick(); end
    drive(0, 0, 0, 1); tick();
    chk("pos11", pos_out, 11);
    chk("pos11_req", refresh_req, 0);
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
`ifdef LED_CTRL_WRAP_EN
    chk("wrap_up_pos", pos_out, 0);
    chk("wrap_up_mask", led_mask, 12'h001);
    chk("wrap_up_req", refresh_req, 1);
`else
    chk("sat_up_pos", pos_out, 11);
    chk("sat_up_mask", led_mask, 12'h800);
    chk("sat_up_req", refresh_req, 0);
`endif

    for (int i = 0; i < 12 && m_pos != 5; i++) begin
      drive(0, 1, 0, 0); tick();
    end
    drive(0, 0, 0, 1); tick();
    drive(1, 1, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("both_pos", pos_out, 5);
    chk("both_req", refresh_req, 0);
    intensity_in = 2'b11; tick();
    chk("int32", intensity_out, 8'd32);
    chk("int32_req", refresh_req, 1);

    drive(1, 0, 0, 1); tick();
    chk("ack_chg_req", refresh_req, 1);
    chk("ack_chg_pos", pos_out, 6);
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    chk("ack2_req", refresh_req, 0);
    drive(1, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    res = 1'b1;
    model_reset();
    #1;
    chk("arst_pos", pos_out, 0);
    chk("arst_mode", mode_out, 0);
    chk("arst_int", intensity_out, 8'd1);
    chk("arst_req", refresh_req, 1);
    chk("arst_mask", led_mask, 12'h001);
    tick();
    res = 1'b0;
    intensity_in = 2'b00;
    drive(0, 0, 0, 1); tick();
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 0);
`ifdef LED_CTRL_WRAP_EN
    chk("wrap_dn_pos", pos_out, 11);
    chk("wrap_dn_req", refresh_req, 1);
`else
    chk("sat_dn_pos", pos_out, 0);
    chk("sat_dn_req", refresh_req, 0);
`endif

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        res = 1'b1;
        model_reset();
        tick();
        res = 1'b0;
      end
      rot_up = ($urandom_range(0, 2) == 0);
      rot_dn = ($urandom_range(0, 2) == 0);
      push = ($urandom_range(0, 4) == 0);
      refresh_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) intensity_in = 2'($urandom_range(0, 3));
      tick();
    end

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
